// File: rtl/torneio_pontuacao.sv
// Round-robin tournament scorer: accepts one pairwise result per handshake,
// accumulates saturating scores, then scans one player per cycle for the winner.
module torneio_pontuacao #(
    parameter  int N_JOG   = 4,
    parameter  int SCORE_W = 5,
    parameter  int WIN_PTS = 2,
    localparam int IW      = (N_JOG > 1) ? $clog2(N_JOG) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               match_valid,
    output logic               match_ready,
    input  logic [IW-1:0]      jog_a,
    input  logic [IW-1:0]      jog_b,
    input  logic               a_vence,
    input  logic               empate_in,
    output logic               err,
    input  logic [IW-1:0]      rd_idx,
    output logic [SCORE_W-1:0] rd_score,
    output logic               done,
    output logic               vitoria,
    output logic               empate,
    output logic [IW-1:0]      winner
);

    localparam int NP = N_JOG * (N_JOG - 1) / 2;
    localparam int CW = $clog2(NP + 1);
    localparam int PW = $clog2(N_JOG * N_JOG);
    localparam int SW = $clog2(N_JOG + 1);
    localparam logic [SCORE_W-1:0] SMAX = '1;

    typedef enum logic [1:0] {COLLECT, RESOLVE, DONE} state_t;

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q [N_JOG];
    logic [SCORE_W-1:0]   score_d [N_JOG];
    logic [N_JOG*N_JOG-1:0] played_q, played_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        scan_q, scan_d;
    logic [SCORE_W-1:0]   max_q, max_d;
    logic [IW-1:0]        first_q, first_d;
    logic                 multi_q, multi_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 vit_q, vit_d;
    logic                 emp_q, emp_d;
    logic [IW-1:0]        win_q, win_d;

    logic [IW-1:0]        lo, hi;
    logic [PW-1:0]        pair_idx;
    logic                 in_range, legal, offer, accept, reject;
    logic [SCORE_W-1:0]   cur;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [31:0] inc);
        logic [31:0] t;
        t = 32'(s) + inc;
        return (t > 32'(SMAX)) ? SMAX : t[SCORE_W-1:0];
    endfunction

    // Played pairs are stored as an N x N bitmap indexed by {min, max}.
    always_comb begin
        lo       = (jog_a < jog_b) ? jog_a : jog_b;
        hi       = (jog_a < jog_b) ? jog_b : jog_a;
        in_range = (32'(jog_a) < N_JOG) && (32'(jog_b) < N_JOG);
        pair_idx = PW'(32'(lo) * N_JOG + 32'(hi));
        legal    = (jog_a != jog_b) && in_range && !played_q[pair_idx];
        offer    = match_valid && (state_q == COLLECT);
        accept   = offer && legal && !clear;
        reject   = offer && !legal && !clear;
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        played_d = played_q;
        cnt_d    = cnt_q;
        scan_d   = scan_q;
        max_d    = max_q;
        first_d  = first_q;
        multi_d  = multi_q;
        err_d    = reject;
        done_d   = done_q;
        vit_d    = vit_q;
        emp_d    = emp_q;
        win_d    = win_q;
        cur      = '0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    played_d[pair_idx] = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (empate_in) begin
                        score_d[jog_a] = sat_add(score_q[jog_a], 32'd1);
                        score_d[jog_b] = sat_add(score_q[jog_b], 32'd1);
                    end else if (a_vence) begin
                        score_d[jog_a] = sat_add(score_q[jog_a], 32'(WIN_PTS));
                    end else begin
                        score_d[jog_b] = sat_add(score_q[jog_b], 32'(WIN_PTS));
                    end
                    if (cnt_q == CW'(NP - 1)) begin
                        state_d = RESOLVE;
                        scan_d  = '0;
                    end
                end
            end
            RESOLVE: begin
                if (32'(scan_q) < N_JOG) begin
                    cur = score_q[scan_q[IW-1:0]];
                    // Strict > keeps the lowest index when scores tie.
                    if (scan_q == '0 || cur > max_q) begin
                        max_d   = cur;
                        first_d = scan_q[IW-1:0];
                        multi_d = 1'b0;
                    end else if (cur == max_q) begin
                        multi_d = 1'b1;
                    end
                    scan_d = scan_q + 1'b1;
                end else begin
                    done_d  = 1'b1;
                    vit_d   = !multi_q;
                    emp_d   = multi_q;
                    win_d   = first_q;
                    state_d = DONE;
                end
            end
            DONE: ;
            default: state_d = COLLECT;
        endcase

        if (clear) begin
            state_d  = COLLECT;
            for (int i = 0; i < N_JOG; i++) score_d[i] = '0;
            played_d = '0;
            cnt_d    = '0;
            scan_d   = '0;
            max_d    = '0;
            first_d  = '0;
            multi_d  = 1'b0;
            err_d    = 1'b0;
            done_d   = 1'b0;
            vit_d    = 1'b0;
            emp_d    = 1'b0;
            win_d    = '0;
        end
    end

    for (genvar gi = 0; gi < N_JOG; gi++) begin : g_score
        always_ff @(posedge clk or posedge reset) begin
            if (reset) score_q[gi] <= '0;
            else       score_q[gi] <= score_d[gi];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= COLLECT;
            played_q <= '0;
            cnt_q    <= '0;
            scan_q   <= '0;
            max_q    <= '0;
            first_q  <= '0;
            multi_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            vit_q    <= 1'b0;
            emp_q    <= 1'b0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            played_q <= played_d;
            cnt_q    <= cnt_d;
            scan_q   <= scan_d;
            max_q    <= max_d;
            first_q  <= first_d;
            multi_q  <= multi_d;
            err_q    <= err_d;
            done_q   <= done_d;
            vit_q    <= vit_d;
            emp_q    <= emp_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        rd_score = '0;
        if (32'(rd_idx) < N_JOG) rd_score = score_q[rd_idx];
    end

    assign match_ready = (state_q == COLLECT);
    assign err         = err_q;
    assign done        = done_q;
    assign vitoria     = vit_q;
    assign empate      = emp_q;
    assign winner      = win_q;

endmodule

// File: tb/tb_torneio_pontuacao.sv
// Bench for torneio_pontuacao: table-driven match vectors with a scoreboard of
// expected err/score values, plus hand-written latency, reset, clear and saturation cases.
module tb_torneio_pontuacao;

    logic       clk = 1'b0;
    logic       reset, clear, match_valid, a_vence, empate_in;
    logic [1:0] jog_a, jog_b, rd_idx;
    logic       match_ready, err, done, vitoria, empate;
    logic [1:0] winner;
    logic [4:0] rd_score;
    logic       s_match_ready, s_err, s_done, s_vitoria, s_empate;
    logic [1:0] s_winner;
    logic [1:0] s_rd_score;

    always #5 clk = ~clk;

    torneio_pontuacao #(.N_JOG(4), .SCORE_W(5), .WIN_PTS(2)) dut (
        .clk(clk), .reset(reset), .clear(clear), .match_valid(match_valid),
        .match_ready(match_ready), .jog_a(jog_a), .jog_b(jog_b), .a_vence(a_vence),
        .empate_in(empate_in), .err(err), .rd_idx(rd_idx), .rd_score(rd_score),
        .done(done), .vitoria(vitoria), .empate(empate), .winner(winner)
    );

    torneio_pontuacao #(.N_JOG(4), .SCORE_W(2), .WIN_PTS(2)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .match_valid(match_valid),
        .match_ready(s_match_ready), .jog_a(jog_a), .jog_b(jog_b), .a_vence(a_vence),
        .empate_in(empate_in), .err(s_err), .rd_idx(rd_idx), .rd_score(s_rd_score),
        .done(s_done), .vitoria(s_vitoria), .empate(s_empate), .winner(s_winner)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        bit         aw;
        bit         dr;
        bit         exp_err;
    } vec_t;

    typedef struct {
        string      nm;
        bit         err;
        logic [1:0] a;
        logic [1:0] b;
        logic [4:0] sa;
        logic [4:0] sb;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    logic [4:0] mdl [4];
    logic [4:0] fin [4];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] madd(input logic [4:0] s, input int inc);
        int t;
        t = int'(s) + inc;
        return (t > 31) ? 5'd31 : t[4:0];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 4; i++) mdl[i] = 5'd0;
    endtask

    task automatic vec(input logic [1:0] a, input logic [1:0] b, input bit aw,
                       input bit dr, input bit e);
        vec_t v;
        v.a = a; v.b = b; v.aw = aw; v.dr = dr; v.exp_err = e;
        tbl.push_back(v);
    endtask

    // Called shortly after a falling edge; returns 2ns after the next falling edge.
    task automatic offer(input vec_t v, input string nm);
        exp_t e;
        jog_a = v.a; jog_b = v.b; a_vence = v.aw; empate_in = v.dr;
        match_valid = 1'b1;
        if (!v.exp_err) begin
            if (v.dr) begin
                mdl[v.a] = madd(mdl[v.a], 1);
                mdl[v.b] = madd(mdl[v.b], 1);
            end else if (v.aw) mdl[v.a] = madd(mdl[v.a], 2);
            else               mdl[v.b] = madd(mdl[v.b], 2);
        end
        e.nm = nm; e.err = v.exp_err; e.a = v.a; e.b = v.b;
        e.sa = mdl[v.a]; e.sb = mdl[v.b];
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        match_valid = 1'b0;
        e = sb.pop_front();
        chk({e.nm, " err"}, 32'(err), 32'(e.err));
        rd_idx = e.a; #1;
        chk({e.nm, " score_a"}, 32'(rd_score), 32'(e.sa));
        rd_idx = e.b; #1;
        chk({e.nm, " score_b"}, 32'(rd_score), 32'(e.sb));
        $display("match %s a=%0d b=%0d aw=%0d dr=%0d err=%0d sa=%0d sb=%0d",
                 nm, v.a, v.b, v.aw, v.dr, err, e.sa, e.sb);
    endtask

    task automatic run_table(input string grp);
        foreach (tbl[i]) offer(tbl[i], $sformatf("%s[%0d]", grp, i));
        tbl.delete();
    endtask

    // Counts falling edges until done rises, bounded.
    task automatic wait_done(input string nm, input int exp_edges);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " done latency"}, 32'(n), 32'(exp_edges));
        chk({nm, " done"}, 32'(done), 32'd1);
    endtask

    task automatic check_scores(input string nm);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            chk($sformatf("%s score%0d", nm, i), 32'(rd_score), 32'(fin[i]));
        end
    endtask

    task automatic do_clear(input string nm, input bit with_valid);
        @(negedge clk);
        clear = 1'b1; match_valid = with_valid; jog_a = 2'd0; jog_b = 2'd1;
        a_vence = 1'b1; empate_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; match_valid = 1'b0;
        chk({nm, " err"}, 32'(err), 32'd0);
        chk({nm, " ready"}, 32'(match_ready), 32'd1);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " vitoria"}, 32'(vitoria), 32'd0);
        chk({nm, " empate"}, 32'(empate), 32'd0);
        for (int i = 0; i < 4; i++) fin[i] = 5'd0;
        check_scores(nm);
        mdl_clear();
        $display("clear %s valid=%0d", nm, with_valid);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; match_valid = 1'b0; a_vence = 1'b0;
        empate_in = 1'b0; jog_a = 2'd0; jog_b = 2'd0; rd_idx = 2'd0;
        mdl_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) fin[i] = 5'd0;
        check_scores("reset");
        chk("reset ready", 32'(match_ready), 32'd1);
        chk("reset done", 32'(done), 32'd0);
        chk("reset vitoria", 32'(vitoria), 32'd0);
        chk("reset empate", 32'(empate), 32'd0);
        chk("reset winner", 32'(winner), 32'd0);
        chk("reset err", 32'(err), 32'd0);

        // Outright win for player 0: scores 6,2,2,2
        vec(0, 1, 1, 0, 0); vec(0, 2, 1, 0, 0); vec(0, 3, 1, 0, 0);
        vec(1, 2, 1, 0, 0); vec(3, 1, 1, 0, 0); vec(2, 3, 1, 0, 0);
        run_table("win");
        chk("win resolve ready", 32'(match_ready), 32'd0);
        wait_done("win", 5);
        chk("win vitoria", 32'(vitoria), 32'd1);
        chk("win empate", 32'(empate), 32'd0);
        chk("win winner", 32'(winner), 32'd0);
        fin[0] = 5'd6; fin[1] = 5'd2; fin[2] = 5'd2; fin[3] = 5'd2;
        check_scores("win");

        // Offer while DONE is ignored
        @(negedge clk);
        jog_a = 2'd1; jog_b = 2'd2; match_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        match_valid = 1'b0;
        chk("done ignore err", 32'(err), 32'd0);
        chk("done hold", 32'(done), 32'd1);
        do_clear("clear_in_done", 1'b1);

        // All draws (a_vence set on some, draw must override)
        vec(0, 1, 1, 1, 0); vec(0, 2, 0, 1, 0); vec(0, 3, 1, 1, 0);
        vec(1, 2, 0, 1, 0); vec(1, 3, 1, 1, 0); vec(2, 3, 0, 1, 0);
        run_table("draw");
        wait_done("draw", 5);
        chk("draw empate", 32'(empate), 32'd1);
        chk("draw vitoria", 32'(vitoria), 32'd0);
        chk("draw winner", 32'(winner), 32'd0);
        for (int i = 0; i < 4; i++) fin[i] = 5'd3;
        check_scores("draw");
        do_clear("clear_after_draw", 1'b0);

        // Illegal offers interleaved; rejects must not advance the match count
        vec(0, 1, 1, 0, 0); vec(1, 0, 1, 0, 1); vec(2, 0, 1, 0, 0);
        vec(2, 2, 1, 0, 1); vec(3, 0, 1, 0, 0); vec(0, 3, 0, 0, 1);
        vec(1, 2, 0, 1, 0); vec(3, 1, 1, 0, 0); vec(3, 2, 0, 1, 0);
        run_table("illegal");
        wait_done("illegal", 5);
        chk("illegal vitoria", 32'(vitoria), 32'd1);
        chk("illegal winner", 32'(winner), 32'd3);
        fin[0] = 5'd2; fin[1] = 5'd1; fin[2] = 5'd4; fin[3] = 5'd5;
        check_scores("illegal");
        do_clear("clear_after_illegal", 1'b0);

        // Asynchronous reset in the middle of RESOLVE
        vec(0, 1, 1, 1, 0); vec(0, 2, 0, 1, 0); vec(0, 3, 1, 1, 0);
        vec(1, 2, 0, 1, 0); vec(1, 3, 1, 1, 0); vec(2, 3, 0, 1, 0);
        run_table("async");
        rd_idx = 2'd0;
        @(negedge clk);
        chk("async pre ready", 32'(match_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async ready", 32'(match_ready), 32'd1);
        chk("async score0", 32'(rd_score), 32'd0);
        chk("async done", 32'(done), 32'd0);
        chk("async err", 32'(err), 32'd0);
        $display("async reset ready=%0d score0=%0d", match_ready, rd_score);
        #1 reset = 1'b0;
        mdl_clear();

        // Saturation on the narrow instance: 2, 3, 3
        fin[0] = 5'd2; fin[1] = 5'd3; fin[2] = 5'd3;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v.a = 2'd0; v.b = 2'(i + 1); v.aw = 1'b1; v.dr = 1'b0; v.exp_err = 1'b0;
            offer(v, $sformatf("sat[%0d]", i));
            rd_idx = 2'd0; #1;
            chk($sformatf("sat score0 after %0d", i), 32'(s_rd_score), 32'(fin[i]));
            chk($sformatf("sat err %0d", i), 32'(s_err), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
